// File: rtl/demux32_1x4_reg.sv
// Registered 1-to-4 demultiplexer: steers bus words into four holding registers,
// selected by S or a rotating pointer, and freezes in HOLD once all four are valid.
`ifndef DATA_INDEX_LIMIT
`define DATA_INDEX_LIMIT 31
`endif

module demux32_1x4_reg #(
  parameter int WIDTH = `DATA_INDEX_LIMIT + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             WE,
  input  logic             AUTO,
  input  logic             ACK,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [3:0]       VAL,
  output logic [1:0]       PTR,
  output logic             FULL,
  output logic             OVR
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] y_r [4];
  logic [WIDTH-1:0] y_s [4];
  logic [3:0]       val_r, val_s;
  logic [1:0]       ptr_r, ptr_s;
  logic             full_r, full_s;
  logic             ovr_r, ovr_s;
  logic [1:0]       tgt_s;
  logic [3:0]       val_wr_s;

  // Next-state and next-register computation; ACK always wins over WE.
  always_comb begin
    state_s = state_r;
    y_s     = y_r;
    val_s   = val_r;
    ptr_s   = ptr_r;
    full_s  = full_r;
    ovr_s   = ovr_r;
    if (AUTO) begin
      tgt_s = ptr_r;
    end else begin
      tgt_s = S;
    end
    val_wr_s = val_r | (4'b0001 << tgt_s);

    case (state_r)
      ST_FILL: begin
        if (ACK) begin
          val_s = 4'b0000;
          ptr_s = 2'b00;
        end else if (WE) begin
          y_s[tgt_s] = D;
          val_s      = val_wr_s;
          if (AUTO) begin
            ptr_s = ptr_r + 2'd1;
          end else begin
            ptr_s = ptr_r;
          end
          if (val_wr_s == 4'b1111) begin
            state_s = ST_HOLD;
            full_s  = 1'b1;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (ACK) begin
          state_s = ST_FILL;
          val_s   = 4'b0000;
          ptr_s   = 2'b00;
          full_s  = 1'b0;
          ovr_s   = 1'b0;
        end else if (WE) begin
          ovr_s = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_FILL;
        val_s   = 4'b0000;
        ptr_s   = 2'b00;
        full_s  = 1'b0;
        ovr_s   = 1'b0;
      end
    endcase
  end

  // State and holding registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_FILL;
      for (int i = 0; i < 4; i++) begin
        y_r[i] <= {WIDTH{1'b0}};
      end
      val_r  <= 4'b0000;
      ptr_r  <= 2'b00;
      full_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      for (int i = 0; i < 4; i++) begin
        y_r[i] <= y_s[i];
      end
      val_r  <= val_s;
      ptr_r  <= ptr_s;
      full_r <= full_s;
      ovr_r  <= ovr_s;
    end
  end

  assign Y0   = y_r[0];
  assign Y1   = y_r[1];
  assign Y2   = y_r[2];
  assign Y3   = y_r[3];
  assign VAL  = val_r;
  assign PTR  = ptr_r;
  assign FULL = full_r;
  assign OVR  = ovr_r;

endmodule

// File: tb/tb_demux32_1x4_reg.sv
// Self-checking bench for demux32_1x4_reg: directed scenarios plus random traffic
// compared against a slot/flag reference model.
module tb_demux32_1x4_reg;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] D = 32'h0;
  logic [1:0]  S = 2'b00;
  logic        WE = 1'b0;
  logic        AUTO = 1'b0;
  logic        ACK = 1'b0;
  logic [31:0] Y0, Y1, Y2, Y3;
  logic [3:0]  VAL;
  logic [1:0]  PTR;
  logic        FULL, OVR;

  demux32_1x4_reg #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .D(D), .S(S), .WE(WE), .AUTO(AUTO), .ACK(ACK),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .VAL(VAL), .PTR(PTR), .FULL(FULL), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: four slots with valid flags, a pointer and frame flags.
  logic [31:0] m_y [4];
  bit          m_val [4];
  int          m_ptr;
  bit          m_full;
  bit          m_ovr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_y[i] = 32'h0;
      m_val[i] = 1'b0;
    end
    m_ptr = 0;
    m_full = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [1:0] s, input logic we,
                            input logic auto, input logic ack);
    int t;
    if (ack) begin
      for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
      m_ptr = 0;
      m_full = 1'b0;
      m_ovr = 1'b0;
    end else if (we) begin
      if (m_full) begin
        m_ovr = 1'b1;
      end else begin
        t = auto ? m_ptr : int'(s);
        m_y[t] = d;
        m_val[t] = 1'b1;
        if (auto) m_ptr = (m_ptr + 1) % 4;
        m_full = m_val[0] && m_val[1] && m_val[2] && m_val[3];
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".Y0"}, Y0, m_y[0]);
    check_eq({ctx, ".Y1"}, Y1, m_y[1]);
    check_eq({ctx, ".Y2"}, Y2, m_y[2]);
    check_eq({ctx, ".Y3"}, Y3, m_y[3]);
    check_eq({ctx, ".VAL"}, {28'h0, VAL}, {28'h0, m_val[3], m_val[2], m_val[1], m_val[0]});
    check_eq({ctx, ".PTR"}, {30'h0, PTR}, 32'(m_ptr));
    check_eq({ctx, ".FULL"}, {31'h0, FULL}, {31'h0, m_full});
    check_eq({ctx, ".OVR"}, {31'h0, OVR}, {31'h0, m_ovr});
  endtask

  task automatic cycle(input string ctx, input logic [31:0] d, input logic [1:0] s,
                       input logic we, input logic auto, input logic ack);
    D = d; S = s; WE = we; AUTO = auto; ACK = ack;
    @(posedge CLK);
    model_step(d, s, we, auto, ack);
    #1;
    check_all(ctx);
  endtask

  logic [31:0] fill_words [4];
  logic [31:0] sel_words [5];
  logic [1:0]  sel_chans [5];

  initial begin
    fill_words = '{32'h00012340, 32'habc21000, 32'h00033300, 32'h00aadd00};
    sel_words  = '{32'h9999ffdd, 32'h0000ade0, 32'h00000001, 32'h00000003, 32'h00000002};
    sel_chans  = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
    model_reset();

    // Reset held with an active write on the bus
    RST = 1'b0; D = 32'hFFFFFFFF; WE = 1'b1; AUTO = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
      check_all("reset");
    end
    @(negedge CLK);
    RST = 1'b1; WE = 1'b0;

    // Auto fill
    for (int i = 0; i < 4; i++) begin
      cycle("auto_fill", fill_words[i], 2'd0, 1'b1, 1'b1, 1'b0);
      check_eq("auto_fill.val_step", {28'h0, VAL}, (32'h1 << (i + 1)) - 32'h1);
    end
    check_eq("auto_fill.y0_const", Y0, 32'h00012340);
    check_eq("auto_fill.y3_const", Y3, 32'h00aadd00);
    check_eq("auto_fill.full_const", {31'h0, FULL}, 32'h1);
    check_eq("auto_fill.ptr_wrap", {30'h0, PTR}, 32'h0);

    // Overrun in HOLD then ACK
    cycle("overrun", 32'hacdefb00, 2'd1, 1'b1, 1'b0, 1'b0);
    check_eq("overrun.ovr_const", {31'h0, OVR}, 32'h1);
    check_eq("overrun.y1_kept", Y1, 32'habc21000);
    cycle("ack", 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_eq("ack.full_const", {31'h0, FULL}, 32'h0);
    check_eq("ack.y2_retained", Y2, 32'h00033300);

    // Explicit select with overwrite
    for (int i = 0; i < 5; i++) begin
      cycle("explicit", sel_words[i], sel_chans[i], 1'b1, 1'b0, 1'b0);
      check_eq("explicit.full_timing", {31'h0, FULL}, (i == 4) ? 32'h1 : 32'h0);
      check_eq("explicit.ptr_zero", {30'h0, PTR}, 32'h0);
    end
    check_eq("explicit.y2_const", Y2, 32'h0000ade0);

    // WE+ACK in HOLD: write dropped, no overrun
    cycle("hold_we_ack", 32'h55555555, 2'd0, 1'b1, 1'b0, 1'b1);
    check_eq("hold_we_ack.ovr_const", {31'h0, OVR}, 32'h0);
    check_eq("hold_we_ack.y0_kept", Y0, 32'h00000001);

    // WE+ACK in FILL with two valid channels
    cycle("fill2", 32'h11111111, 2'd0, 1'b1, 1'b1, 1'b0);
    cycle("fill2", 32'h22222222, 2'd0, 1'b1, 1'b1, 1'b0);
    check_eq("fill2.val_const", {28'h0, VAL}, 32'h3);
    cycle("fill_we_ack", 32'h77777777, 2'd2, 1'b1, 1'b1, 1'b1);
    check_eq("fill_we_ack.val_const", {28'h0, VAL}, 32'h0);
    check_eq("fill_we_ack.y2_kept", Y2, 32'h0000ade0);

    // Async reset mid-frame
    cycle("pre_rst", 32'h0a0a0a0a, 2'd0, 1'b1, 1'b1, 1'b0);
    cycle("pre_rst", 32'h0b0b0b0b, 2'd0, 1'b1, 1'b1, 1'b0);
    WE = 1'b0;
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge CLK);
    RST = 1'b1;
    cycle("post_rst", 32'h09090901, 2'd3, 1'b1, 1'b1, 1'b0);
    check_eq("post_rst.y0_const", Y0, 32'h09090901);
    check_eq("post_rst.ptr_const", {30'h0, PTR}, 32'h1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle("random", $urandom, 2'($urandom_range(3, 0)),
            1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
            1'($urandom_range(9, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
